instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 8-bit processor. It fetches one 8-bit instruction at a time over a ready handshake and latches it. It then steps the datapath through DECODE/EXEC/MEM/WB, driving the per-cycle control strobes (reg_write, alu_src, mem_read, mem_write, mem_to_reg). It sits between instruction/data memory and the register file/ALU, and it detects illegal opcodes and memory stalls that exceed a timeout.

---
 rtl/instr_sequencer.sv | 134 +++++++++++++
 tb/tb_instr_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// +--------------------------------------------------------------------------+
// | instr_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] instr,
  output logic       imem_req,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic [7:0] ir,
  output logic       pc_inc,
  output logic       reg_write,
  output logic       alu_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       retire,
  output logic [7:0] retired_count,
  output logic       illegal,
  output logic       timeout
);

  localparam int unsigned      CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       op;
  logic             op_legal;
  logic             op_is_mem;

  assign op        = ir[7:5];
  assign op_legal  = (op == OP_ADD) || op[2];
  assign op_is_mem = (op == OP_SW) || (op == OP_LW);

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    pc_inc     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        pc_inc   = imem_ready;
        // A completing fetch wins over an expiring wait in the same cycle.
        if (imem_ready)                state_next = S_DECODE;
        else if (wait_cnt == CNT_LAST) state_next = S_FAULT;
      end
      S_DECODE: begin
        if (op_legal) state_next = S_EXEC;
        else          state_next = run ? S_FETCH : S_IDLE;
      end
      S_EXEC: begin
        alu_src    = (op != OP_ADD);
        state_next = op_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_src    = 1'b1;
        mem_read   = (op == OP_LW);
        mem_to_reg = (op == OP_LW);
        mem_write  = (op == OP_SW);
        if (dmem_ready)                state_next = S_WB;
        else if (wait_cnt == CNT_LAST) state_next = S_FAULT;
      end
      S_WB: begin
        reg_write  = (op != OP_SW);
        mem_to_reg = (op == OP_LW);
        retire     = 1'b1;
        state_next = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ir            <= 8'h00;
      retired_count <= 8'd0;
      illegal       <= 1'b0;
      timeout       <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && imem_ready) ir <= instr;
      if (state == S_DECODE && !op_legal) illegal <= 1'b1;
      if (state_next == S_FAULT && state != S_FAULT) timeout <= 1'b1;
      if (state == S_WB) retired_count <= retired_count + 8'd1;
      // Staying in FETCH or MEM implies the access is still waiting.
      if (state_next != state)
        wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_instr_sequencer : randomized transaction-level bench for sequencer     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_instr_sequencer;

  localparam int MT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, pc_inc, reg_write, alu_src, mem_read, mem_write;
  logic       mem_to_reg, retire, illegal, timeout;
  logic [7:0] ir, retired_count;

  always #5 clk = ~clk;

  instr_sequencer #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir(ir), .pc_inc(pc_inc), .reg_write(reg_write), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .retire(retire), .retired_count(retired_count),
    .illegal(illegal), .timeout(timeout)
  );

  typedef logic [25:0] vec_t;
  logic [25:0] act;
  assign act = {imem_req, pc_inc, alu_src, mem_read, mem_write, mem_to_reg,
                reg_write, retire, illegal, timeout, ir, retired_count};

  vec_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cmp_cyc = 0;
  int drv_cyc = 0;
  int retire_at = -1;
  int fetch_start = 0;

  // Architectural view of the sequencer.
  logic [7:0] ir_m = 8'h00;
  logic [7:0] cnt_m = 8'd0;
  bit ill_m = 0;
  bit to_m = 0;
  bit in_idle = 1;

  task automatic check(input string name, input logic [25:0] a, input logic [25:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  always @(negedge clk) begin : compare
    vec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("cycle %0d outputs", cmp_cyc), act, e);
      if (retire) retire_at = cmp_cyc;
      cmp_cyc++;
    end
  end

  function automatic vec_t mk(bit req, bit pci, bit alu, bit mr, bit mw, bit m2r,
                              bit rw, bit ret);
    return {req, pci, alu, mr, mw, m2r, rw, ret, ill_m, to_m, ir_m, cnt_m};
  endfunction

  task automatic tick(input vec_t e);
    exp_q.push_back(e);
    drv_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    instr      = 8'($urandom);
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    run        = 1'($urandom);
  endtask

  task automatic leave_idle();
    if (in_idle) begin
      int k;
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) begin
        noise(); run = 0; tick(mk(0, 0, 0, 0, 0, 0, 0, 0));
      end
      noise(); run = 1; tick(mk(0, 0, 0, 0, 0, 0, 0, 0));
      in_idle = 0;
    end
  endtask

  task automatic do_fetch(input logic [7:0] b, input int fw);
    fetch_start = drv_cyc;
    for (int i = 0; i < fw; i++) begin
      noise(); imem_ready = 0; tick(mk(1, 0, 0, 0, 0, 0, 0, 0));
    end
    noise(); imem_ready = 1; instr = b; tick(mk(1, 1, 0, 0, 0, 0, 0, 0));
    ir_m = b;
  endtask

  task automatic run_instr(input logic [7:0] b, input int fw, input int mw,
                           input bit run_after, output bit retired);
    logic [2:0] op;
    bit legal, is_lw, is_sw;
    op    = b[7:5];
    legal = (op == 3'b000) || op[2];
    is_lw = (op == 3'b110);
    is_sw = (op == 3'b101);
    retired = 0;
    leave_idle();
    do_fetch(b, fw);
    noise(); if (!legal) run = run_after;
    tick(mk(0, 0, 0, 0, 0, 0, 0, 0));
    if (!legal) begin
      ill_m = 1;
      in_idle = !run_after;
      return;
    end
    noise(); tick(mk(0, 0, op != 3'b000, 0, 0, 0, 0, 0));
    if (is_lw || is_sw) begin
      for (int i = 0; i < mw; i++) begin
        noise(); dmem_ready = 0; tick(mk(0, 0, 1, is_lw, is_sw, is_lw, 0, 0));
      end
      noise(); dmem_ready = 1; tick(mk(0, 0, 1, is_lw, is_sw, is_lw, 0, 0));
    end
    noise(); run = run_after; tick(mk(0, 0, 0, 0, 0, is_lw, !is_sw, 1));
    cnt_m = cnt_m + 8'd1;
    in_idle = !run_after;
    retired = 1;
  endtask

  task automatic fault_tail();
    to_m = 1;
    for (int i = 0; i < 8; i++) begin
      noise(); tick(mk(0, 0, 0, 0, 0, 0, 0, 0));
    end
    check("timeout flag", 26'(timeout), 26'd1);
  endtask

  task automatic do_reset();
    #1; rst_n = 0;
    #2;
    check("async reset outputs", act, 26'd0);
    @(posedge clk); #1;
    check("reset held outputs", act, 26'd0);
    rst_n = 1;
    ir_m = 8'h00; cnt_m = 8'd0; ill_m = 0; to_m = 0; in_idle = 1;
  endtask

  task automatic latency(input string name, input int cycles);
    check(name, 26'(retire_at - fetch_start + 1), 26'(cycles));
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit r;
    int retires;
    logic [2:0] op;
    int fw, mw;

    // Reset state.
    #12;
    check("power-on reset outputs", act, 26'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // Zero-wait ALU stream.
    run_instr(8'h00, 0, 0, 1, r); latency("add latency", 4);
    run_instr(8'h81, 0, 0, 1, r); latency("addi latency", 4);
    run_instr(8'hE3, 0, 0, 1, r); latency("sll latency", 4);
    check("ir and count after 3", 26'({ir, retired_count}), 26'h0E303);

    // Memory ops with waits.
    run_instr(8'hC2, 0, 3, 1, r); latency("lw 3-wait latency", 8);
    run_instr(8'hA5, 0, 0, 1, r); latency("sw latency", 5);
    run_instr(8'hA5, 2, 1, 1, r); latency("sw waited latency", 8);

    // Illegal opcode followed by a normal instruction.
    run_instr(8'h40, 0, 0, 1, r);
    check("illegal no retire", 26'(retired_count), 26'd6);
    run_instr(8'h00, 0, 0, 1, r);
    check("illegal sticky", 26'(illegal), 26'd1);
    check("count after illegal", 26'(retired_count), 26'd7);

    // Ready on the last tolerated wait cycle.
    run_instr(8'h00, MT - 1, 0, 1, r);
    run_instr(8'hC0, 0, MT - 1, 0, r);
    check("no timeout at boundary", 26'(timeout), 26'd0);

    // run already low: complete and park in IDLE.
    run_instr(8'h81, 0, 0, 0, r);

    // Reset in the middle of an lw MEM phase.
    leave_idle();
    do_fetch(8'hC2, 0);
    noise(); tick(mk(0, 0, 0, 0, 0, 0, 0, 0));
    noise(); tick(mk(0, 0, 1, 0, 0, 0, 0, 0));
    noise(); dmem_ready = 0; tick(mk(0, 0, 1, 1, 0, 1, 0, 0));
    noise(); dmem_ready = 0;
    #1;
    check("mem_read before reset", 26'({mem_read, mem_to_reg}), 26'd3);
    do_reset();

    // Random stream across the retire-count wrap.
    retires = 0;
    while (retires < 256) begin
      op = 3'($urandom_range(0, 7));
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, MT - 1) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, MT - 1) : $urandom_range(0, 2);
      run_instr({op, 5'($urandom)}, fw, mw, $urandom_range(0, 3) != 0, r);
      if (r) retires++;
      if (retires == 255 && r) check("count at 255", 26'(retired_count), 26'd255);
    end
    check("count wrapped", 26'(retired_count), 26'd0);

    // Fetch timeout.
    do_reset();
    leave_idle();
    fetch_start = drv_cyc;
    for (int i = 0; i < MT; i++) begin
      noise(); imem_ready = 0; tick(mk(1, 0, 0, 0, 0, 0, 0, 0));
    end
    fault_tail();

    // Data-memory timeout on lw.
    do_reset();
    leave_idle();
    do_fetch(8'hC7, 0);
    noise(); tick(mk(0, 0, 0, 0, 0, 0, 0, 0));
    noise(); tick(mk(0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < MT; i++) begin
      noise(); dmem_ready = 0; tick(mk(0, 0, 1, 1, 0, 1, 0, 0));
    end
    fault_tail();
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
